// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: turns one valid/ready request into one
// NONSEQ transfer and reports read data or error on a one-cycle response strobe.
module ahb_lite_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  hclk_i,
    input  logic                  hresetn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  req_write_i,
    input  logic [2:0]            req_size_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i
);

    localparam int unsigned SIZE_MAX = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR2,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WDOG_W-1:0]     r_wdog;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_accept;
    logic                  w_rsp_err_nxt;
    logic                  w_rdata_load;
    logic                  w_req_ok;
    logic                  w_hresp_err;
    logic                  w_wdog_expired;
    logic                  w_busy_now;
    logic                  w_busy_nxt;
    logic [DATA_WIDTH-1:0] w_align_mask;

    // Request legality: size must fit the bus and the address must be size-aligned.
    assign w_align_mask   = (DATA_WIDTH'(1) << req_size_i) - DATA_WIDTH'(1);
    assign w_req_ok       = (req_size_i <= 3'(SIZE_MAX)) &&
                            ((req_addr_i & w_align_mask) == '0);
    assign w_hresp_err    = (hresp_i != 2'b00);
    assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT - 1));
    assign w_busy_now     = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_busy_nxt     = (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA) ||
                            (w_state_nxt == S_ERR2);

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a slave completion in the same cycle wins over the watchdog.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_rsp_err_nxt = 1'b0;
        w_rdata_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_accept = 1'b1;
                    if (w_req_ok) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt   = S_RESP;
                        w_rsp_err_nxt = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (w_wdog_expired) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else if (hready_i) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (hready_i) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = w_hresp_err;
                    w_rdata_load  = !w_hresp_err && !hwrite_o;
                end else if (w_wdog_expired) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else if (w_hresp_err) begin
                    w_state_nxt = S_ERR2;
                end
            end
            S_ERR2: begin
                if (hready_i || w_wdog_expired) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered bus, response and watchdog outputs, loaded from next-state decode.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            haddr_o     <= '0;
            htrans_o    <= HTRANS_IDLE;
            hwrite_o    <= 1'b0;
            hsize_o     <= 3'b000;
            hwdata_o    <= '0;
            r_wdata     <= '0;
            r_wdog      <= '0;
        end else begin
            req_ready_o <= (w_state_nxt == S_IDLE);
            rsp_valid_o <= (w_state_nxt == S_RESP);
            rsp_err_o   <= w_rsp_err_nxt;
            htrans_o    <= (w_state_nxt == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (w_accept) begin
                r_wdata <= req_wdata_i;
            end
            if (w_accept && (w_state_nxt == S_ADDR)) begin
                haddr_o  <= req_addr_i;
                hwrite_o <= req_write_i;
                hsize_o  <= req_size_i;
            end
            hwdata_o <= (((w_state_nxt == S_DATA) || (w_state_nxt == S_ERR2)) && hwrite_o)
                        ? r_wdata : '0;
            if (w_rdata_load) begin
                rsp_rdata_o <= hrdata_i;
            end
            r_wdog <= (w_busy_now && w_busy_nxt) ? r_wdog + WDOG_W'(1) : '0;
        end
    end

endmodule
